stackn: RTL

STACKN -- requirements
Module: stackn

---
 rtl/stackn.sv | 134 +++++++++++++
 1 files changed

// File: rtl/stackn.sv
// stackn: register-based LIFO of DEPTH words with top/next visibility.
// Supports load (overwrite top), swap (exchange top two), push, pop, and
// combined push+pop (replace top). Overflow/underflow are sticky flags.
// Entries at or beyond count are always zero; pops shift a zero into the bottom.
module stackn #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 6,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             push,
    input  logic             pop,
    input  logic             swap,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] qtop,
    output logic [WIDTH-1:0] qnext,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] TWO_C   = CW'(2);

    logic [WIDTH-1:0] e_reg      [DEPTH];
    logic [WIDTH-1:0] e_next     [DEPTH];
    logic [WIDTH-1:0] push_shift [DEPTH];
    logic [WIDTH-1:0] pop_shift  [DEPTH];
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             ovf_reg;
    logic             unf_reg;
    logic             ovf_next;
    logic             unf_next;
    logic             ovf_set;
    logic             unf_set;
    logic             is_empty;
    logic             is_full;

    assign is_empty = (count_reg == '0);
    assign is_full  = (count_reg == DEPTH_C);

    // Precomputed shifted views of the stack: push moves everything down one
    // slot with d on top, pop moves everything up one slot with zero fill.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_shift
            if (gi == 0) begin : g_top
                assign push_shift[gi] = d;
            end else begin : g_rest
                assign push_shift[gi] = e_reg[gi-1];
            end
            if (gi == DEPTH - 1) begin : g_bottom
                assign pop_shift[gi] = '0;
            end else begin : g_upper
                assign pop_shift[gi] = e_reg[gi+1];
            end
        end
    endgenerate

    // Next-state selection; priority is load, then swap, then push/pop.
    always_comb begin
        e_next     = e_reg;
        count_next = count_reg;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        if (load) begin
            e_next[0] = d;
            if (is_empty) begin
                count_next = ONE_C;
            end
        end else if (swap) begin
            if (count_reg >= TWO_C) begin
                e_next[0] = e_reg[1];
                e_next[1] = e_reg[0];
            end else begin
                unf_set = 1'b1;
            end
        end else if (push && pop && !is_empty) begin
            // Replace top in place; depth is unchanged.
            e_next[0] = d;
        end else if (push) begin
            // Also covers push+pop on an empty stack.
            e_next = push_shift;
            if (is_full) begin
                ovf_set = 1'b1;
            end else begin
                count_next = count_reg + ONE_C;
            end
        end else if (pop) begin
            if (is_empty) begin
                unf_set = 1'b1;
            end else begin
                e_next     = pop_shift;
                count_next = count_reg - ONE_C;
            end
        end
        // A new error event outranks a clear in the same cycle.
        ovf_next = ovf_set | (ovf_reg & ~clr_err);
        unf_next = unf_set | (unf_reg & ~clr_err);
    end

    // State registers with asynchronous clear of every entry and flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                e_reg[i] <= '0;
            end
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            e_reg     <= e_next;
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    assign qtop  = e_reg[0];
    assign qnext = e_reg[1];
    assign count = count_reg;
    assign empty = is_empty;
    assign full  = is_full;
    assign ovf   = ovf_reg;
    assign unf   = unf_reg;

endmodule
